// File: rtl/hazard_ctrl_if.sv
// Hazard control bundle: pipeline-side hazard inputs and the resulting
// forwarding selects, stall/flush strobes and perf counters.
// master = pipeline side, slave = hazard_ctrl_unit.
interface hazard_ctrl_if #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    logic [NUM_SRC*ADDR_W-1:0] rs_d_addr;
    logic [NUM_SRC*ADDR_W-1:0] rs_e_addr;
    logic [ADDR_W-1:0]         rde_addr;
    logic [ADDR_W-1:0]         rdm_addr;
    logic [ADDR_W-1:0]         rdw_addr;
    logic [ADDR_W-1:0]         rdt_addr;
    logic                      reg_wr_en_e;
    logic                      reg_wr_en_m;
    logic                      reg_wr_en_w;
    logic                      reg_wr_en_t;
    logic                      mem_rd_e;
    logic                      br_taken_e;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic                      stall_f;
    logic                      stall_d;
    logic                      flush_d;
    logic                      flush_e;
    logic [CNT_W-1:0]          stall_cnt;
    logic [CNT_W-1:0]          flush_cnt;

    modport master (
        output rs_d_addr, rs_e_addr, rde_addr, rdm_addr, rdw_addr, rdt_addr,
        output reg_wr_en_e, reg_wr_en_m, reg_wr_en_w, reg_wr_en_t,
        output mem_rd_e, br_taken_e,
        input  fwd_sel, stall_f, stall_d, flush_d, flush_e, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs_d_addr, rs_e_addr, rde_addr, rdm_addr, rdw_addr, rdt_addr,
        input  reg_wr_en_e, reg_wr_en_m, reg_wr_en_w, reg_wr_en_t,
        input  mem_rd_e, br_taken_e,
        output fwd_sel, stall_f, stall_d, flush_d, flush_e, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Hazard control unit: M/W/T operand forwarding, multi-cycle load-use stall
// FSM and branch-redirect flushing.
// Optional macro HAZARD_PERF_CNT_EN enables saturating stall/flush counters;
// without it the counter ports are tied to zero.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no hazard in progress; a load-use hit here is bubble #1
// S_STALL | remaining load-use bubbles; cnt_q counts them down to 1
module hazard_ctrl_unit #(
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hif
);
    localparam int CNT_LW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_STALL = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [CNT_LW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]     rs_e_i;
    logic [NUM_SRC*2-1:0]  fwd_sel_c;
    logic                  lu;
    logic                  stall_c;
    logic                  flush_d_c;
    logic                  flush_e_c;

    // Per-source forwarding select, M beats W beats T; x0 never forwards
    always_comb begin
        fwd_sel_c = '0;
        rs_e_i    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs_e_i = hif.rs_e_addr[i*ADDR_W +: ADDR_W];
            if (hif.reg_wr_en_m && (hif.rdm_addr != '0) && (rs_e_i == hif.rdm_addr))
                fwd_sel_c[2*i +: 2] = 2'b10;
            else if (hif.reg_wr_en_w && (hif.rdw_addr != '0) && (rs_e_i == hif.rdw_addr))
                fwd_sel_c[2*i +: 2] = 2'b01;
            else if (hif.reg_wr_en_t && (hif.rdt_addr != '0) && (rs_e_i == hif.rdt_addr))
                fwd_sel_c[2*i +: 2] = 2'b11;
        end
        if (rst)
            fwd_sel_c = '0;
    end

    // Load-use detect: a load in E writes a register that D is about to read
    always_comb begin
        lu = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hif.rs_d_addr[i*ADDR_W +: ADDR_W] == hif.rde_addr)
                lu = 1'b1;
        end
        lu = lu & hif.mem_rd_e & hif.reg_wr_en_e & (hif.rde_addr != '0);
    end

    // Stall FSM next-state and strobe decode; a taken branch wins over everything
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_c   = 1'b0;
        flush_d_c = 1'b0;
        flush_e_c = 1'b0;
        if (rst) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (hif.br_taken_e) begin
            flush_d_c = 1'b1;
            flush_e_c = 1'b1;
            state_d   = S_IDLE;
            cnt_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (lu) begin
                        stall_c   = 1'b1;
                        flush_e_c = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = S_STALL;
                            cnt_d   = CNT_LW'(LOAD_LAT - 1);
                        end
                    end
                end
                S_STALL: begin
                    stall_c   = 1'b1;
                    flush_e_c = 1'b1;
                    cnt_d     = cnt_q - CNT_LW'(1);
                    if (cnt_q == CNT_LW'(1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // FSM state and bubble counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hif.fwd_sel = fwd_sel_c;
    assign hif.stall_f = stall_c;
    assign hif.stall_d = stall_c;
    assign hif.flush_d = flush_d_c;
    assign hif.flush_e = flush_e_c;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters; stall_c is already low during reset
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_c && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (hif.br_taken_e && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hif.stall_cnt = stall_cnt_q;
    assign hif.flush_cnt = flush_cnt_q;
`else
    assign hif.stall_cnt = '0;
    assign hif.flush_cnt = '0;
`endif
endmodule
